// File: rtl/alu_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sched
// Brief    : Two-requester round-robin command scheduler for a shared ALU;
//            wide commands run as two chained passes (low then high half).
// Revision : 1.0  initial release
// ============================================================================
module alu_cmd_sched #(
    parameter int ALU_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           i_req_valid,
    output logic [1:0]           o_req_ready,
    input  logic [1:0]           i_req_wide,
    input  logic [1:0]           i_req_mode,
    input  logic [7:0]           i_req_select,
    input  logic [1:0]           i_req_carry,
    input  logic [4*ALU_W-1:0]   i_req_a,
    input  logic [4*ALU_W-1:0]   i_req_b,
    output logic [ALU_W-1:0]     o_alu_in_a,
    output logic [ALU_W-1:0]     o_alu_in_b,
    output logic [3:0]           o_alu_select,
    output logic                 o_alu_mode,
    output logic                 o_alu_carry_in,
    input  logic [ALU_W-1:0]     i_alu_result,
    input  logic                 i_alu_carry_out,
    input  logic                 i_alu_compare,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic                 o_rsp_id,
    output logic [2*ALU_W-1:0]   o_rsp_data,
    output logic                 o_rsp_carry,
    output logic                 o_rsp_equal,
    output logic                 o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]         r_state;
    logic               r_last;
    logic               r_id;
    logic               r_wide;
    logic               r_mode;
    logic [3:0]         r_sel;
    logic               r_carry;
    logic [2*ALU_W-1:0] r_a;
    logic [2*ALU_W-1:0] r_b;
    logic [ALU_W-1:0]   r_lo_res;
    logic [ALU_W-1:0]   r_hi_res;
    logic               r_c_lo;
    logic               r_c_hi;
    logic               r_eq_lo;
    logic               r_eq;

    logic               w_grant;
    logic               w_gnt_id;
    logic               w_resp;

    // Contention goes to the requester that was not served last.
    assign w_gnt_id    = (&i_req_valid) ? ~r_last : i_req_valid[1];
    assign w_grant     = (r_state == S_IDLE) && (|i_req_valid);
    assign o_req_ready = w_grant ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;

    assign w_resp      = (r_state == S_RESP);
    assign o_busy      = (r_state != S_IDLE);
    assign o_rsp_valid = w_resp;
    assign o_rsp_id    = w_resp & r_id;
    assign o_rsp_data  = w_resp ? {(r_wide ? r_hi_res : {ALU_W{1'b0}}), r_lo_res}
                                : {(2*ALU_W){1'b0}};
    assign o_rsp_carry = w_resp & (r_wide ? r_c_hi : r_c_lo);
    assign o_rsp_equal = w_resp & (r_wide ? r_eq : r_eq_lo);

    always_comb begin
        o_alu_in_a     = '0;
        o_alu_in_b     = '0;
        o_alu_select   = 4'd0;
        o_alu_mode     = 1'b0;
        o_alu_carry_in = 1'b0;
        case (r_state)
            S_LO: begin
                o_alu_in_a     = r_a[ALU_W-1:0];
                o_alu_in_b     = r_b[ALU_W-1:0];
                o_alu_select   = r_sel;
                o_alu_mode     = r_mode;
                o_alu_carry_in = r_carry;
            end
            S_HI: begin
                o_alu_in_a     = r_a[2*ALU_W-1:ALU_W];
                o_alu_in_b     = r_b[2*ALU_W-1:ALU_W];
                o_alu_select   = r_sel;
                o_alu_mode     = r_mode;
                // Arithmetic chains the low-pass carry; logic ops keep the command carry.
                o_alu_carry_in = r_mode ? r_carry : r_c_lo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_wide   <= 1'b0;
            r_mode   <= 1'b0;
            r_sel    <= 4'd0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_lo_res <= '0;
            r_hi_res <= '0;
            r_c_lo   <= 1'b0;
            r_c_hi   <= 1'b0;
            r_eq_lo  <= 1'b0;
            r_eq     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state <= S_LO;
                        r_last  <= w_gnt_id;
                        r_id    <= w_gnt_id;
                        r_wide  <= i_req_wide[w_gnt_id];
                        r_mode  <= i_req_mode[w_gnt_id];
                        r_carry <= i_req_carry[w_gnt_id];
                        r_sel   <= w_gnt_id ? i_req_select[7:4] : i_req_select[3:0];
                        r_a     <= w_gnt_id ? i_req_a[4*ALU_W-1:2*ALU_W] : i_req_a[2*ALU_W-1:0];
                        r_b     <= w_gnt_id ? i_req_b[4*ALU_W-1:2*ALU_W] : i_req_b[2*ALU_W-1:0];
                    end
                end
                S_LO: begin
                    r_lo_res <= i_alu_result;
                    r_c_lo   <= i_alu_carry_out;
                    r_eq_lo  <= i_alu_compare;
                    r_state  <= r_wide ? S_HI : S_RESP;
                end
                S_HI: begin
                    r_hi_res <= i_alu_result;
                    r_c_hi   <= i_alu_carry_out;
                    r_eq     <= r_eq_lo & i_alu_compare;
                    r_state  <= S_RESP;
                end
                default: begin
                    if (i_rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
